// File: rtl/az10_pkg.sv
// Shared definitions for the stack arbiter: FSM states, stack op encoding
// and the round-robin selection helpers.
package az10_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_t;

    // First requester with req high, searching upward from rr and wrapping.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] rr);
        logic [1:0] o0;
        logic [1:0] o1;
        logic [1:0] o2;
        case (rr)
            2'd1:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd2:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase
        if (req[o0]) begin
            rr_pick = o0;
        end else if (req[o1]) begin
            rr_pick = o1;
        end else begin
            rr_pick = o2;
        end
    endfunction

    function automatic logic [1:0] rr_next(input logic [1:0] k);
        if (k == 2'd2) begin
            rr_next = 2'd0;
        end else begin
            rr_next = k + 2'd1;
        end
    endfunction

endpackage

// File: rtl/stk_arbiter_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module stk_mem #(
    parameter int DATA_LEN  = 8,
    parameter int STK_DEPTH = 16,
    parameter int AW        = $clog2(STK_DEPTH)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DATA_LEN-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [DATA_LEN-1:0] rdata
);

    logic [DATA_LEN-1:0] mem_r [STK_DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/stk_arbiter.sv
// Three-requester round-robin arbiter in front of a push/pop stack.
// Each granted access takes IDLE -> ACCESS -> RESP, one access per 3 cycles.
module stk_arbiter
    import az10_pkg::*;
#(
    parameter int DATA_LEN  = 8,
    parameter int STK_DEPTH = 16,
    parameter int N_REQ     = 3
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clr,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ-1:0]             op,
    input  logic [N_REQ*DATA_LEN-1:0]    wdata,
    output logic [N_REQ-1:0]             gnt,
    output logic [N_REQ-1:0]             done,
    output logic                         err,
    output logic [DATA_LEN-1:0]          rdata,
    output logic [$clog2(STK_DEPTH):0]   sp,
    output logic                         full,
    output logic                         empty
);

    localparam int AW  = $clog2(STK_DEPTH);
    localparam int SPW = AW + 1;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [1:0]          rr_r;
    logic [1:0]          sel_r;
    logic [1:0]          pick_s;
    op_t                 op_r;
    logic [DATA_LEN-1:0] wdata_r;
    logic [DATA_LEN-1:0] mem_rdata_s;
    logic [DATA_LEN-1:0] rdata_r;
    logic [DATA_LEN-1:0] rdata_nxt_s;
    logic [SPW-1:0]      sp_r;
    logic [SPW-1:0]      sp_nxt_s;
    logic [N_REQ-1:0]    gnt_r;
    logic [N_REQ-1:0]    done_r;
    logic [N_REQ-1:0]    gnt_nxt_s;
    logic [N_REQ-1:0]    done_nxt_s;
    logic                err_r;
    logic                err_nxt_s;
    logic                start_s;
    logic                full_s;
    logic                empty_s;
    logic                push_ok_s;
    logic                pop_ok_s;
    logic [AW-1:0]       waddr_s;
    logic [AW-1:0]       raddr_s;

    assign full_s  = (sp_r == SPW'(STK_DEPTH));
    assign empty_s = (sp_r == {SPW{1'b0}});
    assign pick_s  = rr_pick(req, rr_r);
    assign waddr_s = AW'(sp_r);
    assign raddr_s = AW'(sp_r - SPW'(1));

    stk_mem #(
        .DATA_LEN  (DATA_LEN),
        .STK_DEPTH (STK_DEPTH),
        .AW        (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok_s),
        .waddr (waddr_s),
        .wdata (wdata_r),
        .raddr (raddr_s),
        .rdata (mem_rdata_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic; clr in IDLE blocks arbitration for that cycle
    always_comb begin
        state_nxt_s = ST_IDLE;
        start_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((|req) && !clr) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_ACCESS;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_nxt_s = ST_RESP;
            ST_RESP:   state_nxt_s = ST_IDLE;
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM output decode, registered below so gnt lands in ACCESS and done/err in RESP
    always_comb begin
        gnt_nxt_s  = {N_REQ{1'b0}};
        done_nxt_s = {N_REQ{1'b0}};
        err_nxt_s  = 1'b0;
        if (start_s) begin
            gnt_nxt_s[pick_s] = 1'b1;
        end else begin
            gnt_nxt_s = {N_REQ{1'b0}};
        end
        if (state_r == ST_ACCESS) begin
            done_nxt_s[sel_r] = 1'b1;
            err_nxt_s         = !push_ok_s && !pop_ok_s;
        end else begin
            done_nxt_s = {N_REQ{1'b0}};
            err_nxt_s  = 1'b0;
        end
    end

    // Stack datapath: legality checks, next stack pointer and pop result
    always_comb begin
        push_ok_s   = 1'b0;
        pop_ok_s    = 1'b0;
        sp_nxt_s    = sp_r;
        rdata_nxt_s = rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (clr) begin
                    sp_nxt_s = {SPW{1'b0}};
                end else begin
                    sp_nxt_s = sp_r;
                end
            end
            ST_ACCESS: begin
                push_ok_s = (op_r == OP_PUSH) && !full_s;
                pop_ok_s  = (op_r == OP_POP) && !empty_s;
                if (push_ok_s) begin
                    sp_nxt_s = sp_r + SPW'(1);
                end else if (pop_ok_s) begin
                    sp_nxt_s = sp_r - SPW'(1);
                end else begin
                    sp_nxt_s = sp_r;
                end
                if (op_r == OP_POP) begin
                    rdata_nxt_s = pop_ok_s ? mem_rdata_s : {DATA_LEN{1'b0}};
                end else begin
                    rdata_nxt_s = rdata_r;
                end
            end
            default: begin
                sp_nxt_s    = sp_r;
                rdata_nxt_s = rdata_r;
            end
        endcase
    end

    // Latch the winning request and advance the round-robin pointer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_r    <= 2'd0;
            sel_r   <= 2'd0;
            op_r    <= OP_PUSH;
            wdata_r <= {DATA_LEN{1'b0}};
        end else if (start_s) begin
            rr_r    <= rr_next(pick_s);
            sel_r   <= pick_s;
            op_r    <= op_t'(op[pick_s]);
            wdata_r <= wdata[int'(pick_s)*DATA_LEN +: DATA_LEN];
        end
    end

    // Stack pointer and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sp_r    <= {SPW{1'b0}};
            gnt_r   <= {N_REQ{1'b0}};
            done_r  <= {N_REQ{1'b0}};
            err_r   <= 1'b0;
            rdata_r <= {DATA_LEN{1'b0}};
        end else begin
            sp_r    <= sp_nxt_s;
            gnt_r   <= gnt_nxt_s;
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
            rdata_r <= rdata_nxt_s;
        end
    end

    assign gnt   = gnt_r;
    assign done  = done_r;
    assign err   = err_r;
    assign rdata = rdata_r;
    assign sp    = sp_r;
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: tb/tb_stk_arbiter.sv
// Directed self-checking bench for stk_arbiter: one task per scenario,
// inputs driven and outputs sampled on the falling edge.
module tb_stk_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        clr;
    logic [2:0]  req;
    logic [2:0]  op;
    logic [23:0] wdata;
    logic [2:0]  gnt;
    logic [2:0]  done;
    logic        err;
    logic [7:0]  rdata;
    logic [4:0]  sp;
    logic        full;
    logic        empty;

    int n_cmp = 0;
    int n_bad = 0;

    stk_arbiter #(.DATA_LEN(8), .STK_DEPTH(16), .N_REQ(3)) dut (
        .clk(clk), .rstn(rstn), .clr(clr), .req(req), .op(op), .wdata(wdata),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .sp(sp),
        .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0; req = 3'b000; op = 3'b000; clr = 1'b0; wdata = 24'h0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // One complete access by requester k; returns what was seen at +1 and +2 cycles
    task automatic access(input int k, input bit pop_op, input logic [7:0] d, input bit drop,
                          output logic [2:0] g, output logic [2:0] dn, output logic e,
                          output logic [7:0] rd, output logic [4:0] s);
        @(negedge clk);
        req = 3'b000; op = 3'b000; wdata = 24'h0;
        req[k] = 1'b1; op[k] = pop_op; wdata[k*8 +: 8] = d;
        @(negedge clk);
        g = gnt;
        if (drop) req = 3'b000;
        @(negedge clk);
        dn = done; e = err; rd = rdata; s = sp;
        req = 3'b000;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b0; clr = 1'b0; req = 3'b000; op = 3'b000; wdata = 24'h0;
        #1;
        n_cmp++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL reset_gnt: got %b want 000", gnt); end
        n_cmp++; if (done !== 3'b000) begin n_bad++; $display("FAIL reset_done: got %b want 000", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (rdata !== 8'h00) begin n_bad++; $display("FAIL reset_rdata: got %h want 00", rdata); end
        n_cmp++; if (sp !== 5'd0) begin n_bad++; $display("FAIL reset_sp: got %0d want 0", sp); end
        n_cmp++; if ({full, empty} !== 2'b01) begin n_bad++; $display("FAIL reset_flags: got %b want 01", {full, empty}); end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_single_push_pop();
        logic [2:0] g, dn; logic e; logic [7:0] rd; logic [4:0] s;
        access(0, 1'b0, 8'h2A, 1'b0, g, dn, e, rd, s);
        n_cmp++; if (g !== 3'b001) begin n_bad++; $display("FAIL push_gnt: got %b want 001", g); end
        n_cmp++; if (dn !== 3'b001) begin n_bad++; $display("FAIL push_done: got %b want 001", dn); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL push_err: got %b want 0", e); end
        n_cmp++; if (s !== 5'd1) begin n_bad++; $display("FAIL push_sp: got %0d want 1", s); end
        access(0, 1'b1, 8'h00, 1'b0, g, dn, e, rd, s);
        n_cmp++; if (dn !== 3'b001) begin n_bad++; $display("FAIL pop_done: got %b want 001", dn); end
        n_cmp++; if (rd !== 8'h2A) begin n_bad++; $display("FAIL pop_rdata: got %h want 2a", rd); end
        n_cmp++; if (s !== 5'd0) begin n_bad++; $display("FAIL pop_sp: got %0d want 0", s); end
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL pop_err: got %b want 0", e); end
        @(negedge clk);
        n_cmp++; if (done !== 3'b000) begin n_bad++; $display("FAIL done_pulse: got %b want 000", done); end
    endtask

    task automatic test_round_robin();
        logic [2:0] g, dn, exp_g; logic e; logic [7:0] rd; logic [4:0] s;
        apply_reset();
        @(negedge clk);
        req = 3'b111; op = 3'b000; wdata = {8'h33, 8'h22, 8'h11};
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            exp_g = (c == 1 || c == 10) ? 3'b001 : (c == 4) ? 3'b010 : (c == 7) ? 3'b100 : 3'b000;
            n_cmp++; if (gnt !== exp_g) begin n_bad++; $display("FAIL rr_gnt c%0d: got %b want %b", c, gnt, exp_g); end
        end
        n_cmp++; if (sp !== 5'd4) begin n_bad++; $display("FAIL rr_sp: got %0d want 4", sp); end
        req = 3'b000;
        access(0, 1'b1, 8'h00, 1'b0, g, dn, e, rd, s);
        n_cmp++; if (rd !== 8'h11) begin n_bad++; $display("FAIL rr_pop0: got %h want 11", rd); end
        access(1, 1'b1, 8'h00, 1'b0, g, dn, e, rd, s);
        n_cmp++; if ({dn, rd} !== {3'b010, 8'h33}) begin n_bad++; $display("FAIL rr_pop1: got %b/%h want 010/33", dn, rd); end
        n_cmp++; if (s !== 5'd2) begin n_bad++; $display("FAIL rr_pop_sp: got %0d want 2", s); end
    endtask

    task automatic test_overflow();
        logic [2:0] g, dn; logic e; logic [7:0] rd; logic [4:0] s;
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            access(2, 1'b0, 8'h80 + 8'(i), 1'b0, g, dn, e, rd, s);
            n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL fill_err i%0d: got %b want 0", i, e); end
        end
        n_cmp++; if ({s, full, empty} !== {5'd16, 2'b10}) begin n_bad++; $display("FAIL fill_state: got sp=%0d full=%b empty=%b want 16/1/0", s, full, empty); end
        access(2, 1'b0, 8'hEE, 1'b0, g, dn, e, rd, s);
        n_cmp++; if ({dn, e} !== {3'b100, 1'b1}) begin n_bad++; $display("FAIL ovf_done_err: got %b/%b want 100/1", dn, e); end
        n_cmp++; if (s !== 5'd16) begin n_bad++; $display("FAIL ovf_sp: got %0d want 16", s); end
        access(2, 1'b1, 8'h00, 1'b0, g, dn, e, rd, s);
        n_cmp++; if (rd !== 8'h8F) begin n_bad++; $display("FAIL ovf_top_kept: got %h want 8f", rd); end
        n_cmp++; if ({s, e, full} !== {5'd15, 1'b0, 1'b0}) begin n_bad++; $display("FAIL ovf_pop: got sp=%0d err=%b full=%b want 15/0/0", s, e, full); end
    endtask

    task automatic test_underflow();
        logic [2:0] g, dn; logic e; logic [7:0] rd; logic [4:0] s;
        apply_reset();
        access(1, 1'b0, 8'h55, 1'b0, g, dn, e, rd, s);
        access(1, 1'b1, 8'h00, 1'b0, g, dn, e, rd, s);
        n_cmp++; if (rd !== 8'h55) begin n_bad++; $display("FAIL udf_setup_rdata: got %h want 55", rd); end
        access(1, 1'b1, 8'h00, 1'b0, g, dn, e, rd, s);
        n_cmp++; if ({dn, e} !== {3'b010, 1'b1}) begin n_bad++; $display("FAIL udf_done_err: got %b/%b want 010/1", dn, e); end
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL udf_rdata: got %h want 00", rd); end
        n_cmp++; if (s !== 5'd0) begin n_bad++; $display("FAIL udf_sp: got %0d want 0", s); end
        @(negedge clk);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL udf_err_pulse: got %b want 0", err); end
    endtask

    task automatic test_clear_idle();
        logic [2:0] g, dn; logic e; logic [7:0] rd; logic [4:0] s;
        apply_reset();
        access(0, 1'b0, 8'h01, 1'b0, g, dn, e, rd, s);
        access(0, 1'b0, 8'h02, 1'b0, g, dn, e, rd, s);
        @(negedge clk);
        clr = 1'b1; req = 3'b001; op = 3'b000;
        @(negedge clk);
        clr = 1'b0; req = 3'b000;
        n_cmp++; if (gnt !== 3'b000) begin n_bad++; $display("FAIL clr_idle_gnt: got %b want 000", gnt); end
        n_cmp++; if ({sp, empty} !== {5'd0, 1'b1}) begin n_bad++; $display("FAIL clr_idle_sp: got %0d/%b want 0/1", sp, empty); end
    endtask

    task automatic test_mid_events();
        logic [2:0] g, dn; logic e; logic [7:0] rd; logic [4:0] s;
        apply_reset();
        access(0, 1'b0, 8'h10, 1'b0, g, dn, e, rd, s);
        access(0, 1'b1, 8'h00, 1'b0, g, dn, e, rd, s);
        access(0, 1'b0, 8'h21, 1'b0, g, dn, e, rd, s);
        @(negedge clk);
        req = 3'b001; op = 3'b000; wdata = 24'h000077;
        @(negedge clk);
        clr = 1'b1;
        n_cmp++; if (gnt !== 3'b001) begin n_bad++; $display("FAIL clr_acc_gnt: got %b want 001", gnt); end
        @(negedge clk);
        clr = 1'b0; req = 3'b000;
        n_cmp++; if ({done, sp} !== {3'b001, 5'd2}) begin n_bad++; $display("FAIL clr_acc_resp: got %b/%0d want 001/2", done, sp); end
        @(negedge clk);
        req = 3'b001; op = 3'b000; wdata = 24'h000099;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if ({done, sp, rdata} !== {3'b001, 5'd3, 8'h10}) begin n_bad++; $display("FAIL rst_pre: got %b/%0d/%h want 001/3/10", done, sp, rdata); end
        rstn = 1'b0; req = 3'b000;
        #1;
        n_cmp++; if ({done, gnt, err} !== 7'b0) begin n_bad++; $display("FAIL rst_mid_ctl: got %b/%b/%b want 000/000/0", done, gnt, err); end
        n_cmp++; if ({sp, rdata} !== {5'd0, 8'h00}) begin n_bad++; $display("FAIL rst_mid_data: got %0d/%h want 0/00", sp, rdata); end
        @(negedge clk);
        rstn = 1'b1;
        access(0, 1'b0, 8'h5C, 1'b0, g, dn, e, rd, s);
        n_cmp++; if ({g, dn, s} !== {3'b001, 3'b001, 5'd1}) begin n_bad++; $display("FAIL rst_after: got %b/%b/%0d want 001/001/1", g, dn, s); end
    endtask

    task automatic test_dropped_req();
        logic [2:0] g, dn; logic e; logic [7:0] rd; logic [4:0] s;
        apply_reset();
        access(1, 1'b0, 8'hA1, 1'b0, g, dn, e, rd, s);
        access(1, 1'b0, 8'hA2, 1'b0, g, dn, e, rd, s);
        access(1, 1'b0, 8'hA3, 1'b0, g, dn, e, rd, s);
        n_cmp++; if (s !== 5'd3) begin n_bad++; $display("FAIL drop_setup_sp: got %0d want 3", s); end
        access(1, 1'b1, 8'h00, 1'b1, g, dn, e, rd, s);
        n_cmp++; if (g !== 3'b010) begin n_bad++; $display("FAIL drop_gnt: got %b want 010", g); end
        n_cmp++; if ({dn, s} !== {3'b010, 5'd2}) begin n_bad++; $display("FAIL drop_done_sp: got %b/%0d want 010/2", dn, s); end
        n_cmp++; if ({rd, e} !== {8'hA3, 1'b0}) begin n_bad++; $display("FAIL drop_rdata: got %h/%b want a3/0", rd, e); end
    endtask

    initial begin
        rstn = 1'b0; clr = 1'b0; req = 3'b000; op = 3'b000; wdata = 24'h0;
        test_reset();
        test_single_push_pop();
        test_round_robin();
        test_overflow();
        test_underflow();
        test_clear_idle();
        test_mid_events();
        test_dropped_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stk_arbiter.md
STK_ARBITER -- requirements
Module: stk_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_LEN, default 8, meaning stack word width.
REQ-002 The block SHALL have parameter STK_DEPTH, default 16, meaning number of stack entries (power of two).
REQ-003 The block SHALL have parameter N_REQ, fixed at 3, meaning requesters: 0=PC, 1=ALU, 2=loader.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset; asynchronous, active-low.
REQ-006 clr  input  1  synchronous stack flush.
REQ-007 req  input  N_REQ  per-requester access request; held high until done.
REQ-008 op  input  N_REQ  per-requester operation: 0=push, 1=pop.
REQ-009 wdata  input  N_REQ*DATA_LEN  push data; requester i occupies bits [i*DATA_LEN +: DATA_LEN].
REQ-010 gnt  output  N_REQ  one-hot grant, high one cycle.
REQ-011 done  output  N_REQ  one-hot completion, high one cycle.
REQ-012 err  output  1  overflow/underflow flag, valid with done.
REQ-013 rdata  output  DATA_LEN  pop result, valid with done.
REQ-014 sp  output  $clog2(STK_DEPTH)+1  current entry count.
REQ-015 full, empty  output  1 each  sp==STK_DEPTH and sp==0 respectively.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-017 IDLE SHALL go to ACCESS when any req is high and clr is low; otherwise it SHALL stay in IDLE.
REQ-018 ACCESS SHALL always go to RESP, and RESP SHALL always go to IDLE.
REQ-019 Arbitration SHALL be round-robin: search starts at priority pointer rr (reset 0) and takes the first requester with req high.
REQ-020 On grant to requester k, rr SHALL become (k+1) mod 3.
REQ-021 gnt[k] SHALL be high during the ACCESS cycle; requester index, op and wdata SHALL be latched on the IDLE->ACCESS edge.
REQ-022 A push in ACCESS with sp<STK_DEPTH SHALL write mem[sp] and increment sp.
REQ-023 A pop in ACCESS with sp>0 SHALL decrement sp and capture mem[sp-1] into rdata.
REQ-024 A push when full SHALL leave memory and sp unchanged and set err.
REQ-025 A pop when empty SHALL leave sp unchanged, set rdata=0 and set err.
REQ-026 done[k], err and rdata SHALL be driven during RESP; rdata SHALL hold its value until the next pop completes.
REQ-027 Latency from req sampled in IDLE SHALL be: gnt at +1 cycle, done at +2 cycles; sustained throughput SHALL be one access per 3 cycles.
REQ-028 A req deasserted after grant SHALL NOT abort the access; done SHALL still pulse.
REQ-029 clr in IDLE SHALL set sp=0 and SHALL suppress arbitration that cycle.
REQ-030 clr in ACCESS or RESP SHALL be ignored; the in-flight access SHALL complete.
REQ-031 sp SHALL never wrap; full and empty SHALL be combinational from sp.

Reset
REQ-032 rstn low SHALL immediately force state=IDLE, sp=0, rr=0, gnt=0, done=0, err=0, rdata=0, including mid-transaction.
REQ-033 Memory contents SHALL NOT be reset and are don't-care after reset.

Structure
REQ-034 State encodings and the op encoding (PUSH/POP) SHALL live in the shared az10 package.
REQ-035 Storage SHALL be a sub-module stk_mem: single write port plus one asynchronous read port, no reset.

Verification
REQ-036 Scenario single push/pop: PC pushes 0x2A, then pops -> done[0] at +2 cycles each, rdata=0x2A, sp 0->1->0, err=0.
REQ-037 Scenario round-robin: req=3'b111 held, all pushes -> gnt order 0,1,2,0 on cycles 1,4,7,10.
REQ-038 Scenario overflow: 16 pushes fill the stack (full=1), 17th push -> err=1, sp=16, mem[15] unchanged.
REQ-039 Scenario underflow: pop from empty -> err=1, rdata=0, sp=0.
REQ-040 Scenario mid-operation events: clr asserted in ACCESS -> access completes, sp unchanged by clr; rstn pulsed low in RESP -> done=0, sp=0 immediately, state=IDLE.
REQ-041 Scenario dropped request: ALU pop with sp=3, req[1] dropped in the cycle after IDLE->ACCESS -> done[1] still pulses and sp=2.
